data_mem_responder: RTL

- Synthesizable responder for the GPU's external async data-memory interface: the memory end of the multi-channel read/write valid/ready protocol.
- Holds a 2^ADDR_BITS x DATA_BITS array and serves each channel's request after a programmable latency with a one-cycle ready pulse.
- Used as the data-memory model in GPU-level benches and as on-chip scratch memory in FPGA builds.
- Includes a side-band load port for preloading data before start.

---
 rtl/data_mem_responder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory end of the multi-channel async data-memory interface.
// Each channel runs its own IDLE -> READ_WAIT/WRITE_WAIT -> ACK FSM and answers a
// request with a one-cycle ready pulse a fixed number of edges after acceptance.
//
// Handshake: the initiator holds *_valid (with address/data) high until it
// samples the matching *_ready high; ready is a single-cycle pulse, a request is
// accepted only in IDLE, and everything presented after acceptance is ignored
// until the channel has passed through ACK back to IDLE.
module data_mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CHANNELS-1:0] mem_read_valid,
    input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_read_ready,
    output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0] mem_write_valid,
    input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
    input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0] mem_write_ready,
    input  logic                    load_enable,
    input  logic [ADDR_BITS-1:0]    load_address,
    input  logic [DATA_BITS-1:0]    load_data,
    // Per-channel FSM state: 0 IDLE, 1 READ_WAIT, 2 WRITE_WAIT, 3 ACK
    output logic [1:0]              debug_state [NUM_CHANNELS]
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        ACK        = 2'd3
    } state_t;

    localparam int          DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0]  RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0]  WR_LOAD = 4'(WRITE_LATENCY - 1);

    state_t                 state   [NUM_CHANNELS];
    logic [3:0]             count   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_q  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   wdata_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   mem     [DEPTH];
    logic [NUM_CHANNELS-1:0] wr_fire;

    // Flag channels whose write commits on the coming edge and export FSM state
    always_comb begin
        wr_fire = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            wr_fire[c]     = (state[c] == WRITE_WAIT) && (count[c] == 4'd0);
            debug_state[c] = state[c];
        end
    end

    // Per-channel request FSMs with registered ready pulses and read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c]          <= IDLE;
                count[c]          <= 4'd0;
                addr_q[c]         <= '0;
                wdata_q[c]        <= '0;
                mem_read_data[c]  <= '0;
                mem_read_ready[c] <= 1'b0;
                mem_write_ready[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: begin
                        mem_read_ready[c]  <= 1'b0;
                        mem_write_ready[c] <= 1'b0;
                        // Reads take priority; a pending write waits for a later IDLE
                        if (mem_read_valid[c]) begin
                            addr_q[c] <= mem_read_address[c];
                            count[c]  <= RD_LOAD;
                            state[c]  <= READ_WAIT;
                        end else if (mem_write_valid[c]) begin
                            addr_q[c]  <= mem_write_address[c];
                            wdata_q[c] <= mem_write_data[c];
                            count[c]   <= WR_LOAD;
                            state[c]   <= WRITE_WAIT;
                        end
                    end
                    READ_WAIT: begin
                        if (count[c] == 4'd0) begin
                            // Nonblocking read sees the array before same-edge writes
                            mem_read_data[c]  <= mem[addr_q[c]];
                            mem_read_ready[c] <= 1'b1;
                            state[c]          <= ACK;
                        end else begin
                            count[c] <= count[c] - 4'd1;
                        end
                    end
                    WRITE_WAIT: begin
                        if (count[c] == 4'd0) begin
                            mem_write_ready[c] <= 1'b1;
                            state[c]           <= ACK;
                        end else begin
                            count[c] <= count[c] - 4'd1;
                        end
                    end
                    ACK: begin
                        mem_read_ready[c]  <= 1'b0;
                        mem_write_ready[c] <= 1'b0;
                        state[c]           <= IDLE;
                    end
                    default: state[c] <= IDLE;
                endcase
            end
        end
    end

    // Array writes: load port first, then channels in ascending order so the
    // highest-index channel wins a same-address conflict and any channel beats load
    always_ff @(posedge clk) begin
        if (load_enable) begin
            mem[load_address] <= load_data;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wr_fire[c]) begin
                mem[addr_q[c]] <= wdata_q[c];
            end
        end
    end

endmodule
